// File: rtl/gpio_serial_config_if.sv
// Bundle between the pad-configuration sequencer and its surroundings.
// It carries the start request, the configuration read port and the serial
// chain outputs.
//   master : sequencer side (drives cfg_addr, serial_*, busy, done)
//   slave  : register file / chain / firmware side (drives start, cfg_data)
interface gpio_serial_config_if #(
    parameter int unsigned NUM_GPIO = 38,
    parameter int unsigned CFG_BITS = 13
);
    localparam int unsigned AW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

    logic                start;
    logic [AW-1:0]       cfg_addr;
    logic [CFG_BITS-1:0] cfg_data;
    logic                serial_clock;
    logic                serial_data;
    logic                serial_load;
    logic                busy;
    logic                done;

    modport master (
        input  start,
        input  cfg_data,
        output cfg_addr,
        output serial_clock,
        output serial_data,
        output serial_load,
        output busy,
        output done
    );

    modport slave (
        output start,
        output cfg_data,
        input  cfg_addr,
        input  serial_clock,
        input  serial_data,
        input  serial_load,
        input  busy,
        input  done
    );
endinterface

// File: rtl/gpio_serial_config.sv
// GPIO pad configuration sequencer. On start it fetches one word per pad,
// highest pad first, shifts each word MSB-first down the pad control chain
// and then strobes serial_load so every pad latches its word at once.
//   i_clock : system clock, rising edge
//   i_reset : asynchronous active-high reset
//   io_bus  : master side of gpio_serial_config_if (start, cfg read port,
//             serial_clock/serial_data/serial_load, busy, done)
module gpio_serial_config #(
    parameter int unsigned NUM_GPIO = 38,
    parameter int unsigned CFG_BITS = 13
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    gpio_serial_config_if.master  io_bus
);
    localparam int unsigned AW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
    localparam int unsigned BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShiftLo,
        StShiftHi,
        StLoad,
        StDone
    } state_e;

    state_e              r_state, w_state_d;
    logic [AW-1:0]       r_idx, w_idx_d;
    logic [BW-1:0]       r_bitn, w_bitn_d;
    logic [CFG_BITS-1:0] r_sreg, w_sreg_d;

    logic [AW-1:0] r_cfg_addr, w_cfg_addr_d;
    logic          r_serial_clock, w_serial_clock_d;
    logic          r_serial_data, w_serial_data_d;
    logic          r_serial_load, w_serial_load_d;
    logic          r_busy, w_busy_d;
    logic          r_done, w_done_d;

    // State and datapath registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_bitn  <= '0;
            r_sreg  <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_bitn  <= w_bitn_d;
            r_sreg  <= w_sreg_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_bitn_d  = r_bitn;
        w_sreg_d  = r_sreg;
        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_idx_d   = AW'(NUM_GPIO - 1);
                    w_state_d = StFetch;
                end
            end
            StFetch: begin
                w_sreg_d  = io_bus.cfg_data;
                w_bitn_d  = BW'(CFG_BITS - 1);
                w_state_d = StShiftLo;
            end
            StShiftLo: w_state_d = StShiftHi;
            StShiftHi: begin
                if (r_bitn != '0) begin
                    w_bitn_d  = r_bitn - BW'(1);
                    w_sreg_d  = r_sreg << 1;
                    w_state_d = StShiftLo;
                end else if (r_idx != '0) begin
                    w_idx_d   = r_idx - AW'(1);
                    w_state_d = StFetch;
                end else begin
                    w_state_d = StLoad;
                end
            end
            StLoad:  w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        w_cfg_addr_d     = r_cfg_addr;
        w_serial_clock_d = 1'b0;
        w_serial_data_d  = 1'b0;
        w_serial_load_d  = 1'b0;
        w_busy_d         = (w_state_d != StIdle);
        w_done_d         = 1'b0;
        unique case (w_state_d)
            StFetch:   w_cfg_addr_d = w_idx_d;
            // Data is launched from the shifter value that becomes current on entry
            StShiftLo: w_serial_data_d = w_sreg_d[CFG_BITS-1];
            StShiftHi: begin
                w_serial_clock_d = 1'b1;
                w_serial_data_d  = r_serial_data;
            end
            StLoad:    w_serial_load_d = 1'b1;
            StDone:    w_done_d = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cfg_addr     <= '0;
            r_serial_clock <= 1'b0;
            r_serial_data  <= 1'b0;
            r_serial_load  <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_cfg_addr     <= w_cfg_addr_d;
            r_serial_clock <= w_serial_clock_d;
            r_serial_data  <= w_serial_data_d;
            r_serial_load  <= w_serial_load_d;
            r_busy         <= w_busy_d;
            r_done         <= w_done_d;
        end
    end

    assign io_bus.cfg_addr     = r_cfg_addr;
    assign io_bus.serial_clock = r_serial_clock;
    assign io_bus.serial_data  = r_serial_data;
    assign io_bus.serial_load  = r_serial_load;
    assign io_bus.busy         = r_busy;
    assign io_bus.done         = r_done;
endmodule

// File: tb/tb_gpio_serial_config.sv
// Directed bench for gpio_serial_config: a default 38x13 instance and a
// 2x3 instance sharing one clock and reset.
module tb_gpio_serial_config;
    logic clk = 1'b0;
    bit   clk_run = 1'b0;
    logic rst = 1'b0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    gpio_serial_config_if #(.NUM_GPIO(38), .CFG_BITS(13)) bus0 ();
    gpio_serial_config_if #(.NUM_GPIO(2), .CFG_BITS(3)) bus1 ();

    // Register file models
    assign bus0.cfg_data = 13'h1000 | 13'(bus0.cfg_addr);
    assign bus1.cfg_data = (bus1.cfg_addr == 1'b0) ? 3'b101 : 3'b011;

    gpio_serial_config #(.NUM_GPIO(38), .CFG_BITS(13)) dut0 (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus0.master)
    );

    gpio_serial_config #(.NUM_GPIO(2), .CFG_BITS(3)) dut1 (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus1.master)
    );

    logic [10:0] outs0;
    logic [5:0]  outs1;
    assign outs0 = {bus0.cfg_addr, bus0.serial_clock, bus0.serial_data, bus0.serial_load,
                    bus0.busy, bus0.done};
    assign outs1 = {bus1.cfg_addr, bus1.serial_clock, bus1.serial_data, bus1.serial_load,
                    bus1.busy, bus1.done};

    int total = 0;
    int bad = 0;

    logic [493:0] chain;
    logic         prev_sclk;
    int n_busy, n_rise, n_load, n_done, n_idle, max_idle;
    int last_rise_c, load_c, done_c, last_busy_c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs dut0 for a fixed number of cycles, collecting chain bits and event cycles.
    task automatic watch0(input int cycles, input int pulse_at, input bit hold);
        int idle_run = 0;
        n_busy = 0; n_rise = 0; n_load = 0; n_done = 0; n_idle = 0; max_idle = 0;
        last_rise_c = -1; load_c = -1; done_c = -1; last_busy_c = -1;
        for (int c = 0; c < cycles; c++) begin
            tick();
            bus0.start = hold || (c == pulse_at);
            if (bus0.busy) begin
                n_busy++;
                last_busy_c = c;
                idle_run = 0;
            end else begin
                n_idle++;
                idle_run++;
                if (idle_run > max_idle) max_idle = idle_run;
            end
            if (bus0.serial_clock && !prev_sclk) begin
                chain = {chain[492:0], bus0.serial_data};
                n_rise++;
                last_rise_c = c;
            end
            prev_sclk = bus0.serial_clock;
            if (bus0.serial_load) begin
                n_load++;
                load_c = c;
            end
            if (bus0.done) begin
                n_done++;
                done_c = c;
            end
        end
    endtask

    task automatic check_chain(input string tag);
        logic [12:0] exp_w;
        for (int k = 0; k < 38; k++) begin
            exp_w = 13'h1000 | 13'(k);
            check(tag, 64'(chain[13*k +: 13]), 64'(exp_w));
        end
    endtask

    initial begin
        logic [5:0] sd1;
        int         busy1, load1;
        logic       addr_a, addr_b, prev1;

        bus0.start = 1'b0;
        bus1.start = 1'b0;
        chain = '0;
        prev_sclk = 1'b0;

        // Asynchronous reset with no clock running
        #2 rst = 1'b1;
        #1;
        check("rst_async_outs0", 64'(outs0), 64'd0);
        check("rst_async_outs1", 64'(outs1), 64'd0);

        clk_run = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outs0", 64'(outs0), 64'd0);
        end
        check("idle_outs1", 64'(outs1), 64'd0);

        // Small instance: words 101 (pad 0) and 011 (pad 1)
        sd1 = '0; busy1 = 0; load1 = 0; addr_a = 1'b0; addr_b = 1'b1; prev1 = 1'b0;
        bus1.start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            bus1.start = 1'b0;
            if (c == 0) addr_a = bus1.cfg_addr;
            if (c == 7) addr_b = bus1.cfg_addr;
            if (bus1.busy) busy1++;
            if (bus1.serial_load) load1++;
            if (bus1.serial_clock && !prev1) sd1 = {sd1[4:0], bus1.serial_data};
            prev1 = bus1.serial_clock;
        end
        check("small_bits", 64'(sd1), 64'(6'b011101));
        check("small_addr_first", 64'(addr_a), 64'd1);
        check("small_addr_second", 64'(addr_b), 64'd0);
        check("small_busy", 64'(busy1), 64'd16);
        check("small_load", 64'(load1), 64'd1);

        // Default full load
        chain = '0; prev_sclk = 1'b0;
        bus0.start = 1'b1;
        watch0(1100, -1, 1'b0);
        check("full_busy", 64'(n_busy), 64'd1028);
        check("full_rises", 64'(n_rise), 64'd494);
        check("full_loads", 64'(n_load), 64'd1);
        check("full_dones", 64'(n_done), 64'd1);
        check("full_last_rise", 64'(last_rise_c), 64'd1025);
        check("full_load_cycle", 64'(load_c), 64'd1026);
        check("full_done_cycle", 64'(done_c), 64'd1027);
        check("full_last_busy", 64'(last_busy_c), 64'd1027);
        check_chain("full_chain");

        // Start pulsed mid-sequence is ignored
        chain = '0; prev_sclk = 1'b0;
        bus0.start = 1'b1;
        watch0(1100, 300, 1'b0);
        check("pulse_busy", 64'(n_busy), 64'd1028);
        check("pulse_loads", 64'(n_load), 64'd1);
        check("pulse_dones", 64'(n_done), 64'd1);
        check("pulse_done_cycle", 64'(done_c), 64'd1027);
        check_chain("pulse_chain");

        // Start held: back-to-back sequences with a single idle cycle between
        bus0.start = 1'b1;
        watch0(3000, -1, 1'b1);
        check("held_loads", 64'(n_load), 64'd2);
        check("held_dones", 64'(n_done), 64'd2);
        check("held_idle", 64'(n_idle), 64'd2);
        check("held_idle_run", 64'(max_idle), 64'd1);
        bus0.start = 1'b0;
        for (int i = 0; i < 1100 && bus0.busy; i++) tick();
        check("held_drain", 64'(bus0.busy), 64'd0);

        // Reset mid-shift
        chain = '0; prev_sclk = 1'b0;
        bus0.start = 1'b1;
        watch0(500, -1, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", 64'(outs0), 64'd0);
        repeat (2) tick();
        check("rst_mid_held", 64'(outs0), 64'd0);
        rst = 1'b0;
        watch0(40, -1, 1'b0);
        check("rst_mid_noload", 64'(n_load), 64'd0);
        check("rst_mid_idle", 64'(n_busy), 64'd0);

        chain = '0; prev_sclk = 1'b0;
        bus0.start = 1'b1;
        watch0(1100, -1, 1'b0);
        check("after_rst_busy", 64'(n_busy), 64'd1028);
        check("after_rst_rises", 64'(n_rise), 64'd494);
        check("after_rst_loads", 64'(n_load), 64'd1);
        check_chain("after_rst_chain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpio_serial_config.md
# gpio_serial_config

Sequencer that programs the per-pad configuration of the `mprj_io` GPIO pads through the serial shift chain of GPIO control blocks. On a start request it reads one configuration word per pad from the management-side configuration register file, shifts every word MSB-first onto the chain, and then pulses a load strobe so all pads latch their new mode together. It sits between the housekeeping/management register file and the chain input of the pad control blocks. Firmware triggers it once after setting up the pad modes and before it drives or samples the pads.

## Interface
- `NUM_GPIO`, 38: number of pads, and so of control blocks, on the chain.
- `CFG_BITS`, 13: configuration word width per pad.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request a full chain load; sampled only in IDLE.
- `cfg_addr`  out  $clog2(NUM_GPIO)  pad index of the requested configuration word.
- `cfg_data`  in  CFG_BITS  word for `cfg_addr`; combinational read, valid in the same cycle.
- `serial_clock`  out  1  chain shift clock.
- `serial_data`  out  1  chain data, launched while `serial_clock` is low.
- `serial_load`  out  1  one-cycle strobe; pads latch their shifted word.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a load completes.

## Operation
- All outputs are registered. Reset value of every output is 0, including `cfg_addr`, and state is IDLE. Reset takes effect immediately and aborts any sequence in progress. No `serial_load` is issued for an aborted sequence.
- Counters:
  - `idx` runs from NUM_GPIO-1 down to 0.
  - `bitn` runs from CFG_BITS-1 down to 0.
  - `sreg` is a CFG_BITS-wide shift register.
- States and transitions:
  - IDLE: if `start`=1, load `idx`=NUM_GPIO-1 and go to FETCH. Otherwise stay.
  - FETCH: `cfg_addr`=`idx`. At the cycle end, `sreg`←`cfg_data`, `bitn`←CFG_BITS-1, then go to SHIFT_LO.
  - SHIFT_LO: `serial_clock`=0, `serial_data`=`sreg[CFG_BITS-1]`. Go to SHIFT_HI.
  - SHIFT_HI: `serial_clock`=1, `serial_data` held from SHIFT_LO. Then:
    - if `bitn`≠0: `bitn`−1, `sreg` shifted left by 1, go to SHIFT_LO;
    - else if `idx`≠0: `idx`−1, go to FETCH;
    - else go to LOAD.
  - LOAD: `serial_clock`=0, `serial_data`=0, `serial_load`=1. Go to DONE.
  - DONE: `done`=1, `serial_load`=0. Go to IDLE.
- Chain ordering:
  - The word for pad NUM_GPIO-1 is shifted first and pad 0 last.
  - The chain input is pad 0's block. After the full shift, pad k holds word k.
- `start` is ignored in every state except IDLE. There is no queueing.
- `serial_clock` and `serial_data` are 0 in IDLE, FETCH, LOAD and DONE.

## Timing
- Sequence latency:
  - `start` high in IDLE at edge N means FETCH for pad NUM_GPIO-1 occupies cycle N+1.
  - Each pad takes 1 + 2·CFG_BITS cycles.
  - Total busy cycles = NUM_GPIO·(1+2·CFG_BITS) + 2. With the defaults this is 38·27+2 = 1028.
- `serial_data` changes only on SHIFT_LO entry. It is stable for one full cycle before, and one full cycle after, the `serial_clock` rising edge.
- `serial_load` rises one cycle after the final `serial_clock` high, and lasts exactly 1 cycle.
- `done` rises the cycle after `serial_load`. `busy` drops the cycle after `done`.
- If `start` is held high continuously, the next sequence begins with FETCH two cycles after `done`: one IDLE cycle, then FETCH.

## Test plan
- Reset: assert `reset` with no clock running → all outputs 0 immediately. Release `reset` with `start`=0 for 10 cycles → outputs stay 0.
- Default full load: drive `cfg_data`=13'h1000|`cfg_addr` and capture `serial_data` on each `serial_clock` rise into a 494-bit model chain. Required results:
  - exactly 494 rising edges, then one `serial_load`;
  - model pad k = 13'h1000|k;
  - `busy` high for 1028 cycles;
  - `done` high for 1 cycle.
- Small instance: NUM_GPIO=2, CFG_BITS=3, word0=3'b101, word1=3'b011. Required results:
  - `serial_data` at the rises = 0,1,1,1,0,1;
  - `cfg_addr` = 1 then 0;
  - 16 busy cycles.
- `start` pulsed while a sequence is in progress (at cycle 300) → ignored. Exactly one `serial_load` and one `done`, and total latency unchanged at 1028.
- `start` held high for 3000 cycles → back-to-back sequences separated by exactly one IDLE cycle. Each sequence issues one `serial_load`.
- `reset` asserted mid-shift (cycle 500) → all outputs 0 in the same cycle and no `serial_load`. A subsequent `start` produces a complete 1028-cycle sequence with correct chain contents.
